// File: rtl/gray_bin_conv_pipe.sv
// Bidirectional Gray/binary converter. The conversion is registered into stage 1, and the
// elastic pipeline has STAGES cycles of latency. Gray-mode words are checked for single-bit adjacency.
module gray_bin_conv_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             adj_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err
);

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] m;
  logic [STAGES-1:0] e;
  logic [WIDTH-1:0]  d [STAGES];
  logic [STAGES-1:0] ld;

  logic [WIDTH-1:0]  hist;
  logic              hist_vld;
  logic [WIDTH-1:0]  diff;
  logic              multi_bit;
  logic              err_now;
  logic              in_fire;
  logic [WIDTH-1:0]  conv;
  logic [CNT_W-1:0]  cnt;

  // Stage k may load when out_ready is high, or when any stage from k to the output end is empty.
  // This closed form avoids a combinational chain between the per-stage load bits.
  always_comb begin
    ld = '0;
    for (int k = 0; k < STAGES; k++) begin
      logic tail_full;
      tail_full = 1'b1;
      for (int j = k; j < STAGES; j++) begin
        tail_full = tail_full & v[j];
      end
      ld[k] = out_ready | ~tail_full;
    end
  end

  assign in_ready = ld[0] & ~rst;
  assign in_fire  = in_valid & in_ready;

  assign conv      = in_mode ? bin2gray(in_data) : gray2bin(in_data);
  assign diff      = in_data ^ hist;
  assign multi_bit = |(diff & (diff - WIDTH'(1)));
  assign err_now   = ~in_mode & hist_vld & multi_bit;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            v[0] <= 1'b0;
            m[0] <= 1'b0;
            e[0] <= 1'b0;
            d[0] <= '0;
          end else if (ld[0]) begin
            v[0] <= in_fire;
            if (in_fire) begin
              m[0] <= in_mode;
              e[0] <= err_now;
              d[0] <= conv;
            end
          end
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            v[k] <= 1'b0;
            m[k] <= 1'b0;
            e[k] <= 1'b0;
            d[k] <= '0;
          end else if (ld[k]) begin
            v[k] <= v[k-1];
            if (v[k-1]) begin
              m[k] <= m[k-1];
              e[k] <= e[k-1];
              d[k] <= d[k-1];
            end
          end
        end
      end
    end
  endgenerate

  // A Gray transfer in the same cycle as clr_err still becomes the new valid history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist     <= '0;
      hist_vld <= 1'b0;
    end else if (in_fire && !in_mode) begin
      hist     <= in_data;
      hist_vld <= 1'b1;
    end else if (clr_err) begin
      hist_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr_err) begin
      cnt <= '0;
    end else if (in_fire && err_now && !(&cnt)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign out_mode  = m[STAGES-1];
  assign adj_err   = e[STAGES-1];
  assign err_count = cnt;

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Scoreboard bench for gray_bin_conv_pipe with WIDTH=8, STAGES=2, CNT_W=4, driven by directed vectors.
// The driver pushes the hand-computed result on each accept, and the monitor compares each output transfer.
module tb_gray_bin_conv_pipe;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_mode;
  logic          adj_err;
  logic [CW-1:0] err_count;
  logic          clr_err;

  gray_bin_conv_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode),
    .adj_err(adj_err), .err_count(err_count), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] d;
    logic         m;
    logic         e;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  bit   lat_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out: got data %0h with no word expected", out_data);
      end else begin
        x = q.pop_front();
        chk("out_word{mode,err,data}", {22'd0, out_mode, adj_err, out_data}, {22'd0, x.m, x.e, x.d});
        if (x.lat) chk("latency", cyc - x.acc, S);
      end
    end
  end

  task automatic send(input logic [W-1:0] din, input logic mode, input logic [W-1:0] xd, input logic xe);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = din;
    in_mode  = mode;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{xd, mode, xe, cyc, lat_mode});
        done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("FAIL accept_timeout: got no accept of %0h, required accept within 100 cycles", din);
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && q.size() != 0; t++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d words pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic clr_pulse();
    @(posedge clk);
    #1;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  logic [W-1:0] g2b_tab [16] = '{8'd0, 8'd1, 8'd3, 8'd2, 8'd7, 8'd6, 8'd4, 8'd5,
                                 8'd15, 8'd14, 8'd12, 8'd13, 8'd8, 8'd9, 8'd11, 8'd10};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
    out_ready = 1'b1; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_adj_err", adj_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Gray 0..15 back-to-back: each odd->even step flips more than one bit
    lat_mode = 1'b1;
    for (int i = 0; i < 16; i++) send(W'(i), 1'b0, g2b_tab[i], (i > 0) && (i % 2 == 0));
    lat_mode = 1'b0;
    drain();
    chk("seq_err_count", err_count, 7);

    send(8'd200, 1'b1, 8'hAC, 1'b0);
    drain();
    chk("b2g_err_count", err_count, 7);

    // Backpressure: two words fill the pipe and the third must wait
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h11, 1'b1, 8'h19, 1'b0);
    send(8'h22, 1'b1, 8'h33, 1'b0);
    in_valid = 1'b1; in_data = 8'h33; in_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data_hold", out_data, 8'h19);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h33, 1'b1, 8'h2A, 1'b0);
    drain();

    // Adjacency and clear
    clr_pulse();
    chk("clr_count", err_count, 0);
    send(8'h00, 1'b0, 8'h00, 1'b0);
    send(8'h01, 1'b0, 8'h01, 1'b0);
    send(8'h01, 1'b0, 8'h01, 1'b0);
    send(8'h07, 1'b0, 8'h05, 1'b1);
    drain();
    chk("adj_count", err_count, 1);
    clr_pulse();
    chk("adj_clr_count", err_count, 0);
    send(8'hFF, 1'b0, 8'hAA, 1'b0);
    // Clear in the same cycle as a Gray transfer: the flag is kept, the count stays 0, and the word becomes history
    clr_err = 1'b1;
    send(8'h00, 1'b0, 8'h00, 1'b1);
    clr_err = 1'b0;
    drain();
    chk("clr_same_cycle_count", err_count, 0);
    send(8'h01, 1'b0, 8'h01, 1'b0);
    drain();
    chk("after_clr_history_count", err_count, 0);

    // Saturation: 19 violations into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) send(8'h00, 1'b0, 8'h00, i != 0);
      else            send(8'h03, 1'b0, 8'h02, 1'b1);
    end
    drain();
    chk("sat_count", err_count, 4'hF);

    // Reset asserted between edges while two words are in flight
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h05, 1'b1, 8'h07, 1'b0);
    send(8'h06, 1'b1, 8'h05, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_in_ready", in_ready, 0);
    q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;
    send(8'h55, 1'b0, 8'h66, 1'b0);
    drain();
    chk("post_rst_count", err_count, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before 200000");
    $fatal(1);
  end

endmodule
